// File: rtl/fifo_rd_packer_if.sv
// Read-side FIFO port plus packed-word valid/ready output of the read packer.
// master = packer side, slave = FIFO/consumer side.
interface fifo_rd_packer_if #(
   parameter int DATA_WIDTH = 8,
   parameter int PACK_RATIO = 4
);
   logic                             empty;
   logic [DATA_WIDTH-1:0]            rd_data;
   logic                             r_inc;
   logic                             flush;
   logic [DATA_WIDTH*PACK_RATIO-1:0] out_data;
   logic [PACK_RATIO-1:0]            out_be;
   logic                             out_valid;
   logic                             out_ready;
   logic                             out_last;

   modport master (
      input  empty, rd_data, flush, out_ready,
      output r_inc, out_data, out_be, out_valid, out_last
   );

   modport slave (
      output empty, rd_data, flush, out_ready,
      input  r_inc, out_data, out_be, out_valid, out_last
   );
endinterface

// File: rtl/fifo_rd_packer.sv
// Drains a first-word-fall-through FIFO and packs PACK_RATIO entries per output
// word; FLUSH closes a partial word so trailing bytes never get stranded.
module fifo_rd_packer #(
   parameter int DATA_WIDTH = 8,
   parameter int PACK_RATIO = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   fifo_rd_packer_if.master pk_if
);
   localparam int IDXW = $clog2(PACK_RATIO);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(PACK_RATIO - 1);

   typedef enum logic {COLLECT, HOLD} state_e;

   state_e                                 state_q, state_d;
   logic [IDXW-1:0]                        idx_q, idx_d;
   logic [PACK_RATIO-1:0][DATA_WIDTH-1:0]  lanes_q, lanes_d;
   logic [PACK_RATIO-1:0]                  be_q, be_d;
   logic                                   last_q, last_d;
   logic                                   accept, cap, hs;

   // A pop is allowed whenever the current word slot can absorb the head entry,
   // including the cycle in which a held word is handed off.
   assign hs     = (state_q == HOLD) & pk_if.out_ready;
   assign accept = (state_q == COLLECT) | hs;
   assign cap    = rst_ni & ~pk_if.empty & accept;

   assign pk_if.r_inc     = cap;
   assign pk_if.out_data  = lanes_q;
   assign pk_if.out_be    = be_q;
   assign pk_if.out_last  = last_q;
   assign pk_if.out_valid = (state_q == HOLD);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= COLLECT;
         idx_q   <= '0;
         lanes_q <= '0;
         be_q    <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         lanes_q <= lanes_d;
         be_q    <= be_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      lanes_d = lanes_q;
      be_d    = be_q;
      last_d  = last_q;
      unique case (state_q)
         COLLECT: begin
            if (cap) begin
               lanes_d[idx_q] = pk_if.rd_data;
               be_d[idx_q]    = 1'b1;
               if (idx_q == LAST_IDX || pk_if.flush) begin
                  state_d = HOLD;
                  idx_d   = '0;
                  last_d  = pk_if.flush;
               end else begin
                  idx_d = idx_q + IDXW'(1);
               end
            end else if (pk_if.flush && idx_q != '0) begin
               state_d = HOLD;
               idx_d   = '0;
               last_d  = 1'b1;
            end
         end
         HOLD: begin
            // FLUSH is deliberately ignored here; the word is already closed.
            if (hs) begin
               state_d = COLLECT;
               lanes_d = '0;
               be_d    = '0;
               last_d  = 1'b0;
               idx_d   = '0;
               if (cap) begin
                  lanes_d[0] = pk_if.rd_data;
                  be_d[0]    = 1'b1;
                  idx_d      = IDXW'(1);
               end
            end
         end
         default: state_d = COLLECT;
      endcase
   end
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: queue-based reference model feeds a scoreboard,
// an independent monitor pops and checks every handed-off word.
module tb_fifo_rd_packer;
   localparam int DW = 8;
   localparam int PR = 4;

   typedef struct {
      logic [DW*PR-1:0] data;
      logic [PR-1:0]    be;
      logic             last;
   } word_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fifo_rd_packer_if #(.DATA_WIDTH(DW), .PACK_RATIO(PR)) bus ();
   fifo_rd_packer #(.DATA_WIDTH(DW), .PACK_RATIO(PR)) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .pk_if (bus)
   );

   word_t         sb[$];
   logic [DW-1:0] cur[$];
   bit            pend = 1'b0;
   int            checks = 0;
   int            errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a list of bytes gathered so far and a flag for a word awaiting hand-off.
   task automatic model_edge(input bit e, input logic [DW-1:0] d, input bit f, input bit r);
      bit    coll, cap;
      word_t w;
      coll = !pend;
      cap  = !e && (!pend || r);
      if (pend && r) pend = 1'b0;
      if (cap) cur.push_back(d);
      if (coll && (cur.size() == PR || (f && cur.size() > 0))) begin
         w.data = '0;
         w.be   = '0;
         foreach (cur[i]) begin
            w.data[i*DW +: DW] = cur[i];
            w.be[i]            = 1'b1;
         end
         w.last = f;
         sb.push_back(w);
         cur.delete();
         pend = 1'b1;
      end
   endtask

   // Called at posedge+1; inputs are held through the next posedge.
   task automatic cyc(input bit e, input logic [DW-1:0] d, input bit f, input bit r);
      bus.empty     = e;
      bus.rd_data   = d;
      bus.flush     = f;
      bus.out_ready = r;
      @(negedge clk);
      chk("r_inc", {63'd0, bus.r_inc}, {63'd0, (!e && (!pend || r))});
      chk("out_valid", {63'd0, bus.out_valid}, {63'd0, pend});
      model_edge(e, d, f, r);
      @(posedge clk);
      #1;
   endtask

   // Monitor: compares every handshaked word and checks hold stability.
   initial begin
      word_t w, prev;
      bit    held;
      held = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n && bus.out_valid) begin
            if (held) begin
               chk("hold_data", bus.out_data, prev.data);
               chk("hold_be", bus.out_be, prev.be);
            end
            if (bus.out_ready) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_word: got %0h expected none", bus.out_data);
               end else begin
                  w = sb.pop_front();
                  chk("word_data", bus.out_data, w.data);
                  chk("word_be", bus.out_be, w.be);
                  chk("word_last", bus.out_last, w.last);
               end
               held = 1'b0;
            end else begin
               held      = 1'b1;
               prev.data = bus.out_data;
               prev.be   = bus.out_be;
            end
         end else begin
            held = 1'b0;
         end
      end
   end

   initial begin
      bus.empty = 1'b0; bus.rd_data = 8'h5A; bus.flush = 1'b0; bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_r_inc", bus.r_inc, 0);
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_be", bus.out_be, 0);
      chk("rst_data", bus.out_data, 0);
      rst_n = 1'b1;

      // Streaming, no bubble
      for (int i = 1; i <= 8; i++) begin
         cyc(1'b0, 8'(i * 8'h11), 1'b0, 1'b1);
         if (i == 4) chk("stream_w0", bus.out_data, 32'h44332211);
         if (i == 8) chk("stream_w1", bus.out_data, 32'h88776655);
      end
      cyc(1'b1, 8'h00, 1'b0, 1'b1);

      // Backpressure
      for (int i = 0; i < 4; i++) cyc(1'b0, 8'(8'hE0 + i), 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) cyc(1'b0, 8'hFF, 1'b0, 1'b0);
      cyc(1'b0, 8'h9E, 1'b0, 1'b1);
      chk("bp_lane0", bus.out_data[7:0], 8'h9E);
      for (int i = 0; i < 3; i++) cyc(1'b0, 8'(8'h90 + i), 1'b0, 1'b1);
      cyc(1'b1, 8'h00, 1'b0, 1'b1);

      // Flush partial, then FLUSH held with nothing collected
      cyc(1'b0, 8'hA1, 1'b0, 1'b1);
      cyc(1'b0, 8'hB2, 1'b0, 1'b1);
      cyc(1'b1, 8'h00, 1'b1, 1'b0);
      chk("fl_data", bus.out_data, 32'h0000B2A1);
      chk("fl_be", bus.out_be, 4'b0011);
      chk("fl_last", bus.out_last, 1);
      for (int i = 0; i < 4; i++) cyc(1'b1, 8'h00, 1'b1, 1'b1);

      // Coincident flush on 3rd, then on 4th capture
      cyc(1'b0, 8'hC1, 1'b0, 1'b1);
      cyc(1'b0, 8'hC2, 1'b0, 1'b1);
      cyc(1'b0, 8'hC3, 1'b1, 1'b0);
      chk("cf3_be", bus.out_be, 4'b0111);
      chk("cf3_lane2", bus.out_data[23:16], 8'hC3);
      chk("cf3_last", bus.out_last, 1);
      cyc(1'b1, 8'h00, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) cyc(1'b0, 8'(8'hD0 + i), 1'b0, 1'b1);
      cyc(1'b0, 8'hD3, 1'b1, 1'b0);
      chk("cf4_be", bus.out_be, 4'hF);
      chk("cf4_last", bus.out_last, 1);
      cyc(1'b1, 8'h00, 1'b0, 1'b1);

      // Randomized traffic
      for (int i = 0; i < 3000; i++)
         cyc(($urandom_range(0, 9) < 3), 8'($urandom), ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 9) < 7));
      for (int i = 0; i < 3; i++) cyc(1'b1, 8'h00, 1'b0, 1'b1);

      // Reset mid-word
      cyc(1'b0, 8'h31, 1'b0, 1'b1);
      cyc(1'b0, 8'h32, 1'b0, 1'b1);
      bus.empty = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("mrst_r_inc", bus.r_inc, 0);
      chk("mrst_be", bus.out_be, 0);
      chk("mrst_data", bus.out_data, 0);
      chk("mrst_valid", bus.out_valid, 0);
      cur.delete();
      sb.delete();
      pend = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) cyc(1'b0, 8'(8'h41 + i), 1'b0, 1'b0);
      chk("mrst_word", bus.out_data, 32'h44434241);
      chk("mrst_word_be", bus.out_be, 4'hF);
      for (int i = 0; i < 3; i++) cyc(1'b1, 8'h00, 1'b0, 1'b1);

      chk("sb_empty", 64'(sb.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/fifo_rd_packer.md
# fifo_rd_packer

Read-domain stage that drains the asynchronous FIFO's read port and packs consecutive DATA_WIDTH-bit entries into PACK_RATIO-lane words. It presents those words on a valid/ready output with per-lane byte enables. It runs entirely on the FIFO read clock and drives the FIFO's read-increment. A FLUSH input emits a partially filled word so that trailing bytes are never stranded in the packer.

## Interface
- DATA_WIDTH, 8, width of one FIFO entry (one lane)
- PACK_RATIO, 4, lanes per output word; power of two, ≥2
- CLK  in  1  read-domain clock, rising edge
- RST  in  1  asynchronous, active-low reset
- EMPTY  in  1  FIFO empty flag
- RD_DATA  in  DATA_WIDTH  FIFO head entry; valid whenever EMPTY=0 (first-word fall-through)
- R_INC  out  1  FIFO pop; combinational
- FLUSH  in  1  level request to emit the current partial word
- OUT_DATA  out  DATA_WIDTH*PACK_RATIO  packed word; lane 0 = first byte popped, in bits [DATA_WIDTH-1:0]
- OUT_BE  out  PACK_RATIO  lane enables; bit i set = lane i holds data
- OUT_VALID  out  1  word available
- OUT_READY  in  1  consumer accepts the word
- OUT_LAST  out  1  word was closed by FLUSH

## Operation
- Registers:
  - state ∈ {COLLECT, HOLD}
  - idx: next lane, clog2(PACK_RATIO) bits
  - lane registers
  - be register
  - last register
- Reset (RST=0, asynchronous):
  - state=COLLECT, idx=0
  - all lanes=0, OUT_BE=0, OUT_VALID=0, OUT_LAST=0
  - R_INC is forced 0 while RST=0.
- accept = (state==COLLECT) | (state==HOLD & OUT_READY)
- R_INC = RST & ~EMPTY & accept. A byte is "captured" on every rising edge where R_INC=1.
- COLLECT state:
  - OUT_VALID=0.
  - On capture: lane[idx]←RD_DATA, be[idx]←1, idx←idx+1.
  - Capture into lane PACK_RATIO-1 closes the word: →HOLD, idx←0, OUT_VALID←1. last←FLUSH in that same cycle.
  - FLUSH=1 with (idx>0 or a capture this cycle) and the word not already closed by a full capture: the word closes with the lanes filled so far (including any byte captured this cycle). →HOLD, OUT_VALID←1, last←1, idx←0.
  - FLUSH=1 with idx=0 and no capture: no action. Empty words are never emitted.
- HOLD state:
  - OUT_VALID=1. OUT_DATA, OUT_BE and OUT_LAST are stable until the handshake.
  - FLUSH is ignored in HOLD.
  - Handshake (OUT_VALID & OUT_READY) clears all lanes, be and last. Then:
    - with a capture in the same cycle: lane0←RD_DATA, be[0]←1, idx←1, →COLLECT;
    - with no capture: idx←0, →COLLECT, OUT_VALID←0.
- Unfilled lanes of a flushed word read 0 and have OUT_BE bit 0. OUT_BE is always contiguous from lane 0.
- idx never wraps silently; it only returns to 0 when a word closes.
- Reset mid-word discards partial data. No word is emitted and FIFO state is untouched.

## Timing
- Zero-cycle pop: R_INC follows EMPTY/OUT_READY combinationally in the same cycle.
- Latency: the edge that captures the last lane (or processes FLUSH) raises OUT_VALID immediately after that edge.
- Throughput: one byte per cycle sustained when EMPTY=0 and OUT_READY=1. Back-to-back full words go out every PACK_RATIO cycles with no bubble.
- Backpressure: with OUT_READY=0 in HOLD, R_INC=0 and the FIFO fills. No data is lost.
- EMPTY going high mid-word stalls idx; the word completes when data resumes.
- FLUSH latency: one edge from FLUSH (in COLLECT, idx>0) to OUT_VALID.

## Test plan
- Reset: hold RST=0 with EMPTY=0 → R_INC=0, OUT_VALID=0, OUT_BE=0, OUT_DATA=0. Release → R_INC=1 in the first cycle.
- Streaming: bytes 0x11,0x22,0x33,0x44,0x55… with OUT_READY=1 → OUT_DATA=0x44332211, BE=4'hF, LAST=0 one cycle after the 4th pop. Next word 0x88776655 follows with no bubble; R_INC stays high throughout.
- Backpressure: complete a word with OUT_READY=0 for 5 cycles → OUT_DATA stable, R_INC=0 for all 5 cycles. Raise OUT_READY with EMPTY=0 → handshake and pop in the same cycle; the new byte lands in lane 0.
- Flush partial: pop 0xA1,0xB2, then EMPTY=1, FLUSH=1 → OUT_DATA=0x0000B2A1, BE=4'b0011, LAST=1. FLUSH held with idx=0 → no second word.
- Coincident flush: FLUSH=1 in the same cycle as the 3rd capture 0xC3 → BE=4'b0111, lane2=0xC3, LAST=1. FLUSH on the 4th capture → BE=4'hF, LAST=1.
- Reset mid-word: pop 2 bytes, assert RST=0 asynchronously between edges → outputs clear immediately. After release, the next 4 bytes form a clean word with no stale lanes.
